// File: rtl/cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_mem_arbiter
//
// Arbitrates the single-port data RAM between the CPU Memory stage
// (single-word loads/stores) and the VGA scanout reader (fixed-length read
// bursts). RAM commands and grants are combinational from the current state
// and the requests. Read data returns one cycle after its command and is
// steered to its owner by a registered return tag.
//
// Ports
//   clk, rst_b              clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata   CPU access request (held until cpu_gnt)
//   cpu_gnt                 CPU access issued to RAM this cycle
//   cpu_rvalid/rdata        CPU read return, one cycle after the read grant
//   cpu_stall               cpu_req & ~cpu_gnt, stalls the pipeline
//   vid_req/urgent/addr     VGA burst request, FIFO low flag, burst base
//   vid_gnt                 first VGA beat issued this cycle
//   vid_rvalid/rdata        one pulse per returned VGA beat
//   ram_en/we/addr/wdata    RAM command
//   ram_rdata               RAM data, valid one cycle after a read command
// ---------------------------------------------------------------------------
module cpu_mem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int BURST    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_b,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,

  input  logic              vid_req,
  input  logic              vid_urgent,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,

  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_VBURST = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  // 1 = VGA won the last arbitration, 0 = CPU.
  logic                last_vga_q, last_vga_d;

  // Return tags: which requester owns the data arriving next cycle.
  logic                cpu_tag_q, cpu_tag_d;
  logic                vid_tag_q, vid_tag_d;

  logic [DATA_W-1:0]   cpu_hold_q;
  logic [DATA_W-1:0]   vid_hold_q;

  logic                pick_cpu;
  logic                pick_vid;

  // ---------------------------------------------------------------------
  // Arbitration decision (only meaningful in IDLE)
  // ---------------------------------------------------------------------
  always_comb begin
    pick_cpu = 1'b0;
    pick_vid = 1'b0;
    if (cpu_req && (wait_q == WAIT_MAX)) begin
      // Starvation bound reached: CPU beats even an urgent VGA request.
      pick_cpu = 1'b1;
    end else if (vid_req && vid_urgent) begin
      pick_vid = 1'b1;
    end else if (cpu_req && vid_req) begin
      // Round-robin on a tie: whoever did not win last time.
      pick_cpu = last_vga_q;
      pick_vid = ~last_vga_q;
    end else if (cpu_req) begin
      pick_cpu = 1'b1;
    end else if (vid_req) begin
      pick_vid = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Next state, grants and RAM command
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    base_d     = base_q;
    last_vga_d = last_vga_q;
    cpu_gnt    = 1'b0;
    vid_gnt    = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    cpu_tag_d  = 1'b0;
    vid_tag_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Held quiet while reset is asserted so no command leaks out
        // during an asynchronous reset with requests still present.
        if (rst_b) begin
          if (pick_cpu) begin
            cpu_gnt    = 1'b1;
            ram_en     = 1'b1;
            ram_we     = cpu_we;
            ram_addr   = cpu_addr;
            ram_wdata  = cpu_we ? cpu_wdata : '0;
            cpu_tag_d  = ~cpu_we;
            last_vga_d = 1'b0;
          end else if (pick_vid) begin
            vid_gnt    = 1'b1;
            ram_en     = 1'b1;
            ram_addr   = vid_addr;
            vid_tag_d  = 1'b1;
            base_d     = vid_addr;
            beat_d     = BEAT_W'(1);
            last_vga_d = 1'b1;
            if (BURST > 1) begin
              state_d = S_VBURST;
            end
          end
        end
      end

      S_VBURST: begin
        // Remaining beats; address wraps naturally at 2^ADDR_W.
        ram_en    = 1'b1;
        ram_addr  = base_q + ADDR_W'(beat_q);
        vid_tag_d = 1'b1;
        beat_d    = beat_q + BEAT_W'(1);
        if (beat_q == LAST_BEAT) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // CPU wait counter: counts blocked cycles, saturates at MAX_WAIT.
  always_comb begin
    wait_d = wait_q;
    if (!cpu_req || cpu_gnt) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      base_q     <= '0;
      wait_q     <= '0;
      last_vga_q <= 1'b1;
      cpu_tag_q  <= 1'b0;
      vid_tag_q  <= 1'b0;
      cpu_hold_q <= '0;
      vid_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      wait_q     <= wait_d;
      last_vga_q <= last_vga_d;
      cpu_tag_q  <= cpu_tag_d;
      vid_tag_q  <= vid_tag_d;
      if (cpu_tag_q) begin
        cpu_hold_q <= ram_rdata;
      end
      if (vid_tag_q) begin
        vid_hold_q <= ram_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read return: data passes straight through in the tagged cycle and is
  // held afterwards so rdata stays stable while rvalid is low.
  // ---------------------------------------------------------------------
  assign cpu_rvalid = cpu_tag_q;
  assign vid_rvalid = vid_tag_q;
  assign cpu_rdata  = cpu_tag_q ? ram_rdata : cpu_hold_q;
  assign vid_rdata  = vid_tag_q ? ram_rdata : vid_hold_q;

  assign cpu_stall  = cpu_req & ~cpu_gnt;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
module tb_cpu_mem_arbiter;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 32;
  localparam int BURST    = 4;
  localparam int MAX_WAIT = 8;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_b = 1'b1;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              vid_req = 1'b0;
  logic              vid_urgent = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic              vid_gnt;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;

  int n_total = 0;
  int n_pass  = 0;

  cpu_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_b(rst_b),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .vid_req(vid_req), .vid_urgent(vid_urgent), .vid_addr(vid_addr),
    .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Block RAM: one-cycle read latency.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------
  // Reference model: pending VGA beats are a queue of addresses; memory is
  // a plain array updated by the writes the model expects to be issued.
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [ADDR_W-1:0] beat_q[$];
  int                m_wait;
  bit                m_last_vga;
  bit                m_cpu_pend, m_vid_pend;
  logic [DATA_W-1:0] m_cpu_pdata, m_vid_pdata, m_cpu_hold, m_vid_hold;

  always @(negedge clk) begin
    bit                e_en, e_we, e_cg, e_vg, cwin, vwin;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd;
    if (!rst_b) begin
      beat_q.delete();
      m_wait = 0; m_last_vga = 1'b1;
      m_cpu_pend = 1'b0; m_vid_pend = 1'b0;
      m_cpu_hold = '0; m_vid_hold = '0;
      chk("rst_ram_en", ram_en, 0);
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_vid_gnt", vid_gnt, 0);
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_vid_rvalid", vid_rvalid, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_vid_rdata", vid_rdata, 0);
    end else begin
      if (m_cpu_pend) m_cpu_hold = m_cpu_pdata;
      if (m_vid_pend) m_vid_hold = m_vid_pdata;
      chk("cpu_rvalid", cpu_rvalid, m_cpu_pend);
      chk("vid_rvalid", vid_rvalid, m_vid_pend);
      chk("cpu_rdata", cpu_rdata, m_cpu_hold);
      chk("vid_rdata", vid_rdata, m_vid_hold);
      m_cpu_pend = 1'b0; m_vid_pend = 1'b0;
      e_en = 0; e_we = 0; e_cg = 0; e_vg = 0; e_addr = '0; e_wd = '0;
      cwin = 0; vwin = 0;
      if (beat_q.size() > 0) begin
        e_en = 1; e_addr = beat_q.pop_front();
        m_vid_pend = 1'b1; m_vid_pdata = model_mem[e_addr];
      end else begin
        if (cpu_req && m_wait == MAX_WAIT) cwin = 1;
        else if (vid_req && vid_urgent)    vwin = 1;
        else if (cpu_req && vid_req)       begin cwin = m_last_vga; vwin = !m_last_vga; end
        else if (cpu_req)                  cwin = 1;
        else if (vid_req)                  vwin = 1;
      end
      if (cwin) begin
        e_cg = 1; e_en = 1; e_we = cpu_we; e_addr = cpu_addr;
        if (cpu_we) begin e_wd = cpu_wdata; model_mem[cpu_addr] = cpu_wdata; end
        else begin m_cpu_pend = 1'b1; m_cpu_pdata = model_mem[cpu_addr]; end
        m_last_vga = 1'b0;
      end
      if (vwin) begin
        e_vg = 1; e_en = 1; e_addr = vid_addr;
        m_vid_pend = 1'b1; m_vid_pdata = model_mem[vid_addr];
        for (int k = 1; k < BURST; k++) beat_q.push_back(vid_addr + ADDR_W'(k));
        m_last_vga = 1'b1;
      end
      if (!cpu_req || e_cg) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
      chk("cpu_gnt", cpu_gnt, e_cg);
      chk("vid_gnt", vid_gnt, e_vg);
      chk("cpu_stall", cpu_stall, cpu_req && !e_cg);
      chk("ram_en", ram_en, e_en);
      chk("ram_we", ram_we, e_we);
      chk("ram_wdata", ram_wdata, e_wd);
      if (e_en) chk("ram_addr", ram_addr, e_addr);
    end
  end

  // ---------------------------------------------------------------------
  // Directed stimulus with hand-computed expectations
  // ---------------------------------------------------------------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 0; vid_urgent = 0; vid_addr = '0;
  endtask

  task automatic do_reset;
    tick; rst_b = 0; clear_inputs();
    tick; rst_b = 1;
  endtask

  localparam logic [11:0] TIE_CPU = 12'b1000_0100_0010;
  localparam logic [11:0] TIE_VID = 12'b0100_0010_0001;

  initial begin
    logic [ADDR_W-1:0] exp_addr [4];
    logic [11:0]       tie_c, tie_v;
    logic [ADDR_W-1:0] op_addr [6];
    logic [DATA_W-1:0] op_data [6];
    bit                op_we [6];
    int                lat;
    bit                done;

    for (int i = 0; i < DEPTH; i++) begin
      mem[i]       = 32'hA5A50000 | i;
      model_mem[i] = 32'hA5A50000 | i;
    end
    #1 rst_b = 0;
    @(negedge clk);
    chk("reset_cpu_rdata", cpu_rdata, 32'h0);
    chk("reset_vid_rvalid", vid_rvalid, 0);
    tick; rst_b = 1;

    // Lone CPU: write then read back.
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h0010; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("lone_wr_gnt", cpu_gnt, 1);
    chk("lone_wr_stall", cpu_stall, 0);
    tick; cpu_we = 0; cpu_wdata = '0;
    @(negedge clk);
    chk("lone_rd_gnt", cpu_gnt, 1);
    chk("lone_rd_stall", cpu_stall, 0);
    tick; cpu_req = 0;
    @(negedge clk);
    chk("lone_rvalid", cpu_rvalid, 1);
    chk("lone_rdata", cpu_rdata, 32'hDEADBEEF);
    tick;

    // Lone VGA burst wrapping past the top of memory.
    exp_addr[0] = 14'h3FFE; exp_addr[1] = 14'h3FFF; exp_addr[2] = 14'h0000; exp_addr[3] = 14'h0001;
    vid_req = 1; vid_addr = 14'h3FFE;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk("burst_addr", ram_addr, exp_addr[b]);
      chk("burst_gnt", vid_gnt, (b == 0));
      chk("burst_rvalid", vid_rvalid, (b != 0));
      tick; vid_req = 0;
    end
    @(negedge clk);
    chk("burst_last_rvalid", vid_rvalid, 1);
    chk("burst_last_rdata", vid_rdata, 32'hA5A50001);
    chk("burst_done_en", ram_en, 0);
    tick;
    @(negedge clk);
    chk("burst_rvalid_end", vid_rvalid, 0);

    // Tie, round-robin, from reset.
    do_reset();
    cpu_req = 1; cpu_addr = 14'h0020; vid_req = 1; vid_addr = 14'h0100;
    tie_c = TIE_CPU; tie_v = TIE_VID;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("tie_cpu_gnt", cpu_gnt, tie_c[11-c]);
      chk("tie_vid_gnt", vid_gnt, tie_v[11-c]);
      chk("tie_stall", cpu_stall, !tie_c[11-c]);
      tick;
    end

    // Urgent VGA starves CPU until the wait bound forces a grant.
    do_reset();
    vid_req = 1; vid_urgent = 1; vid_addr = 14'h0200;
    @(negedge clk);
    chk("urg_vid_gnt", vid_gnt, 1);
    tick; cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0040;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_gnt) begin lat = i; break; end
      tick;
    end
    chk("starve_latency", lat, 11);
    tick;
    @(negedge clk);
    chk("urg_after_cpu_vid", vid_gnt, 1);
    chk("urg_after_cpu_cpu", cpu_gnt, 0);
    tick; clear_inputs();
    repeat (5) tick;

    // Reset on beat 2 of a burst.
    do_reset();
    vid_req = 1; vid_addr = 14'h0300;
    @(negedge clk);
    chk("rb_gnt", vid_gnt, 1);
    tick; vid_req = 0;
    @(negedge clk);
    chk("rb_beat1", ram_addr, 14'h0301);
    tick; rst_b = 0;
    @(negedge clk);
    chk("rb_en", ram_en, 0);
    chk("rb_rvalid", vid_rvalid, 0);
    tick; rst_b = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rb_no_stale", vid_rvalid, 0);
      chk("rb_idle_en", ram_en, 0);
      tick;
    end

    // CPU writes/reads interleaved with continuous non-urgent VGA traffic.
    op_addr[0] = 14'h0050; op_data[0] = 32'h11110050; op_we[0] = 1;
    op_addr[1] = 14'h0051; op_data[1] = 32'h22220051; op_we[1] = 1;
    op_addr[2] = 14'h0052; op_data[2] = 32'h33330052; op_we[2] = 1;
    op_addr[3] = 14'h0050; op_data[3] = 32'h0;        op_we[3] = 0;
    op_addr[4] = 14'h0051; op_data[4] = 32'h0;        op_we[4] = 0;
    op_addr[5] = 14'h0052; op_data[5] = 32'h0;        op_we[5] = 0;
    vid_req = 1; vid_addr = 14'h0400;
    for (int o = 0; o < 6; o++) begin
      cpu_req = 1; cpu_we = op_we[o]; cpu_addr = op_addr[o]; cpu_wdata = op_data[o];
      done = 0;
      for (int t = 0; t < 12; t++) begin
        @(negedge clk);
        if (cpu_gnt) begin done = 1; break; end
        tick;
      end
      chk("mix_gnt_seen", done, 1);
      tick;
    end
    cpu_req = 0; cpu_we = 0; cpu_wdata = '0;
    @(negedge clk);
    chk("mix_last_rvalid", cpu_rvalid, 1);
    chk("mix_last_rdata", cpu_rdata, 32'h33330052);
    tick; vid_req = 0;
    repeat (6) tick;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Arbiter for the single shared data RAM, used by two requesters: the Memory pipeline stage (CPU loads/stores) and the VGA scanout reader. VGA gets fixed-length read bursts. CPU accesses are single-word. A wait counter bounds CPU starvation, and a combinational stall tells the pipeline when a CPU access is blocked. The block sits between cpu_memory, the video reader and the block RAM.

## Interface
- ADDR_W, 14, RAM word-address width
- DATA_W, 32, RAM data width
- BURST, 4, VGA beats per grant (≥1)
- MAX_WAIT, 8, CPU wait cycles before forced priority (≥BURST)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_b  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  combinational; access issued to RAM this cycle
- cpu_rvalid  out  1  registered; cpu_rdata valid (reads only)
- cpu_rdata  out  DATA_W  read data
- cpu_stall  out  1  combinational; cpu_req & ~cpu_gnt, to pipeline stall
- vid_req  in  1  burst request, held until vid_gnt
- vid_urgent  in  1  video FIFO below low watermark
- vid_addr  in  ADDR_W  burst base address
- vid_gnt  out  1  combinational; first beat issued this cycle
- vid_rvalid  out  1  registered; one pulse per beat
- vid_rdata  out  DATA_W  beat data
- ram_en, ram_we  out  1  RAM command
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM data, valid one cycle after a read command

## Operation
- States:
  - IDLE: arbitrates every cycle.
  - VBURST: issues the remaining VGA beats.
- Arbitration in IDLE, in priority order:
  - (1) cpu_req and wait_cnt==MAX_WAIT → CPU
  - (2) vid_req and vid_urgent → VGA
  - (3) both requesting → the requester not granted last (last_win bit)
  - (4) a single requester wins
  - (5) none → ram_en=0
- CPU win:
  - cpu_gnt=1; ram_en=1, ram_we=cpu_we, ram_addr=cpu_addr, ram_wdata=cpu_wdata.
  - State stays IDLE; last_win←CPU; wait_cnt←0.
- VGA win:
  - vid_gnt=1; ram_en=1, ram_we=0, ram_addr=vid_addr.
  - Latch base←vid_addr, beat←1; last_win←VGA.
  - Next state is VBURST if BURST>1, else IDLE.
- VBURST:
  - Each cycle: ram_en=1, ram_we=0, ram_addr=base+beat (modulo 2^ADDR_W, wraps), beat increments.
  - After issuing beat BURST-1, returns to IDLE.
  - Never preempted. vid_gnt=0 and cpu_gnt=0 throughout.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle with cpu_req=1 and cpu_gnt=0.
  - Clears on cpu_gnt and when cpu_req=0.
- Read return:
  - One cycle after a read command, the matching rvalid=1 with rdata=ram_rdata. Owner is tracked by a registered tag.
  - CPU writes produce no rvalid.
- Output defaults: rdata outputs hold their last value when rvalid=0. ram_wdata=0 when no CPU write is issued.

## Timing
- Reset values:
  - State IDLE; beat=0, base=0; wait_cnt=0; last_win=VGA, so the CPU wins the first tie.
  - cpu_rvalid=0, vid_rvalid=0; cpu_rdata=0, vid_rdata=0.
  - The return tag is cleared.
- Command and grant timing:
  - RAM command and grant occur in the same cycle (combinational from state and requests).
  - Read data arrives 1 cycle after the grant/beat.
- VGA burst: BURST consecutive ram cycles; vid_rvalid pulses on cycles N+1..N+BURST.
- Bubble-free handoff: the cycle after the last beat is IDLE and may grant either requester.
- Worst-case CPU latency from cpu_req to cpu_gnt: MAX_WAIT+BURST cycles.
- Reset mid-burst: asynchronously returns to IDLE; in-flight rvalids are dropped (no pulse after rst_b deassertion).
- Requests dropped before grant are legal; nothing is issued.

## Test plan
- Lone CPU:
  - Stimulus: write addr 0x0010 data 0xDEADBEEF, then read 0x0010.
  - Required: cpu_gnt in the request cycle each time; cpu_rvalid one cycle after the read grant with 0xDEADBEEF; cpu_stall never 1.
- Lone VGA burst:
  - Stimulus: vid_addr=0x3FFE, BURST=4.
  - Required: ram_addr 0x3FFE, 0x3FFF, 0x0000, 0x0001 on consecutive cycles; vid_gnt only on the first; four vid_rvalid pulses, each 1 cycle after its command.
- Tie, round-robin:
  - Stimulus: cpu_req and vid_req held continuously, urgent=0, out of reset.
  - Required: CPU, then a 4-cycle VGA burst, then CPU, and so on; cpu_stall=1 exactly during the burst cycles.
- Urgent VGA and CPU starvation:
  - Stimulus: vid_req and vid_urgent held high, cpu_req asserted while a burst is in progress.
  - Required: wait_cnt reaches 8; CPU is granted at the first IDLE after that; cpu_gnt within 12 cycles of cpu_req.
- Reset mid-burst:
  - Stimulus: assert rst_b=0 on beat 2.
  - Required: immediately ram_en=0 and rvalids=0; after release, state IDLE and no stale vid_rvalid.
